ssd_scan_driver: RTL and testbench

//  Consumer of the dispenser's four static 7-segment patterns (digit4..digit1): time-multiplexes them onto
//  one shared active-low segment bus with active-low anodes. Adds coherent frame-boundary update, per-digit

---
 rtl/ssd_pkg.sv | 27 ++
 rtl/ssd_slot_timer.sv | 44 ++++
 rtl/ssd_scan_driver.sv | 133 +++++++++++++
 tb/tb_ssd_scan_driver.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
//------------------------------------------------------------------------------
// Module   : ssd_pkg
// Purpose  : Shared constants for the 4-digit 7-segment scan driver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam logic [1:0] IDX_D1 = 2'd0;
  localparam logic [1:0] IDX_D2 = 2'd1;
  localparam logic [1:0] IDX_D3 = 2'd2;
  localparam logic [1:0] IDX_D4 = 2'd3;

  // Counter width that stays legal even for a modulus of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssd_slot_timer.sv
//------------------------------------------------------------------------------
// Module   : ssd_slot_timer
// Purpose  : Digit slot counter, scan index and frame boundary pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ssd_slot_timer
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 50_000,
  parameter int SLOT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic [1:0]        idx,
  output logic              frame_tick
);

  localparam logic [SLOT_W-1:0] c_slot_last = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] c_slot_prev = SLOT_W'(REFRESH_DIV - 2);

  // frame_tick is set one cycle early so it is high exactly in the cycle
  // whose closing edge wraps idx from digit1 back to digit4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt   <= '0;
      idx        <= IDX_D4;
      frame_tick <= 1'b0;
    end else begin
      if (slot_cnt == c_slot_last) begin
        slot_cnt <= '0;
        idx      <= idx - 2'd1;
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
      frame_tick <= (idx == IDX_D1) && (slot_cnt == c_slot_prev);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ssd_scan_driver.sv
//------------------------------------------------------------------------------
// Module   : ssd_scan_driver
// Purpose  : Time-multiplexed 4-digit 7-segment driver with frame-coherent
//            updates, blank/blink, anti-ghosting guard and brightness PWM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = 50_000,
  parameter int GUARD        = 500,
  parameter int BLINK_FRAMES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg4_in,
  input  logic [6:0] seg3_in,
  input  logic [6:0] seg2_in,
  input  logic [6:0] seg1_in,
  input  logic       load,
  input  logic [3:0] blank_mask,
  input  logic [3:0] blink_mask,
  input  logic [2:0] brightness,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       frame_tick,
  output logic       load_ack
);

  localparam int SLOT_W = cnt_width(REFRESH_DIV);
  localparam int FRM_W  = cnt_width(BLINK_FRAMES);
  localparam logic [FRM_W-1:0] c_frm_last = FRM_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0] w_slot_cnt;
  logic [1:0]        w_idx;
  logic              w_frame_tick;

  ssd_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .SLOT_W      (SLOT_W)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .slot_cnt   (w_slot_cnt),
    .idx        (w_idx),
    .frame_tick (w_frame_tick)
  );

  logic [3:0][6:0]  r_shd_pat, r_act_pat;
  logic [3:0]       r_shd_blank, r_shd_blink, r_act_blank, r_act_blink;
  logic             r_pending, r_act_valid;
  logic [FRM_W-1:0] r_frame_cnt;
  logic             r_blink_phase;
  logic [6:0]       r_seg_n;
  logic [3:0]       r_an_n;
  logic             w_commit;

  assign w_commit = w_frame_tick & r_pending;

  // r_act_valid keeps the display dark after reset until a pattern set commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shd_pat   <= {4{SEG_BLANK}};
      r_shd_blank <= '0;
      r_shd_blink <= '0;
      r_pending   <= 1'b0;
      r_act_pat   <= {4{SEG_BLANK}};
      r_act_blank <= '0;
      r_act_blink <= '0;
      r_act_valid <= 1'b0;
    end else begin
      if (w_commit) begin
        r_act_pat   <= r_shd_pat;
        r_act_blank <= r_shd_blank;
        r_act_blink <= r_shd_blink;
        r_act_valid <= 1'b1;
      end
      if (load) begin
        r_shd_pat   <= {seg4_in, seg3_in, seg2_in, seg1_in};
        r_shd_blank <= blank_mask;
        r_shd_blink <= blink_mask;
        r_pending   <= 1'b1;
      end else if (w_commit) begin
        r_pending   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_tick) begin
      if (r_frame_cnt == c_frm_last) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt   <= r_frame_cnt + FRM_W'(1);
      end
    end
  end

  logic [31:0] w_slot_ext, w_on_cycles;
  logic        w_en;

  assign w_slot_ext  = 32'(w_slot_cnt);
  assign w_on_cycles = (32'(REFRESH_DIV - GUARD) * (32'(brightness) + 32'd1)) >> 3;
  assign w_en        = r_act_valid
                     && (w_slot_ext >= 32'(GUARD))
                     && (w_slot_ext < (32'(GUARD) + w_on_cycles))
                     && !r_act_blank[w_idx]
                     && !(r_act_blink[w_idx] && r_blink_phase);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_n <= SEG_BLANK;
      r_an_n  <= AN_OFF;
    end else begin
      r_seg_n <= w_en ? r_act_pat[w_idx] : SEG_BLANK;
      r_an_n  <= w_en ? ~(4'b0001 << w_idx) : AN_OFF;
    end
  end

  assign seg_n      = r_seg_n;
  assign an_n       = r_an_n;
  assign frame_tick = w_frame_tick;
  assign load_ack   = w_commit;

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
//------------------------------------------------------------------------------
// Module   : tb_ssd_scan_driver
// Purpose  : Directed frame-by-frame checks of ssd_scan_driver (DIV=9, GUARD=1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ssd_scan_driver;
  import ssd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg4_in = '0, seg3_in = '0, seg2_in = '0, seg1_in = '0;
  logic       load = 1'b0;
  logic [3:0] blank_mask = '0, blink_mask = '0;
  logic [2:0] brightness = 3'd7;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       frame_tick, load_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int fno     = 0;

  ssd_scan_driver #(
    .REFRESH_DIV  (9),
    .GUARD        (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg4_in    (seg4_in),
    .seg3_in    (seg3_in),
    .seg2_in    (seg2_in),
    .seg1_in    (seg1_in),
    .load       (load),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_tick (frame_tick),
    .load_ack   (load_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Patterns indexed by scan index: [3] = digit4 ... [0] = digit1.
  localparam logic [3:0][6:0] P    = {SEG_1, SEG_0, SEG_1, SEG_0};
  localparam logic [3:0][6:0] ALL0 = {SEG_0, SEG_0, SEG_0, SEG_0};
  localparam logic [3:0][6:0] ALL1 = {SEG_1, SEG_1, SEG_1, SEG_1};

  // Runs one 36-cycle frame starting just after a boundary edge. Sample j
  // shows slot j%9 of digit index 3-j/9; lit slots are 1..bright+1.
  task automatic check_frame(input logic [3:0][6:0] pat, input logic [3:0] vis,
                             input int bright, input logic exp_ack,
                             input int ld1, input logic [3:0][6:0] p1,
                             input logic [3:0] bk1, input logic [3:0] bl1,
                             input int ld2, input logic [3:0][6:0] p2);
    int         slot, di;
    logic       lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    brightness = 3'(bright);
    for (int j = 0; j < 36; j++) begin
      @(posedge clk);
      @(negedge clk);
      slot  = j % 9;
      di    = 3 - j / 9;
      lit   = vis[di] && (slot >= 1) && (slot <= bright + 1);
      e_an  = lit ? ~(4'b0001 << di) : 4'b1111;
      e_seg = lit ? pat[di] : 7'h7F;
      check($sformatf("an_n f%0d j%0d", fno, j), 32'(an_n), 32'(e_an));
      check($sformatf("seg_n f%0d j%0d", fno, j), 32'(seg_n), 32'(e_seg));
      check($sformatf("frame_tick f%0d j%0d", fno, j), 32'(frame_tick), 32'(j == 34));
      check($sformatf("load_ack f%0d j%0d", fno, j), 32'(load_ack), 32'(exp_ack && j == 34));
      if (j == ld1) begin
        {seg4_in, seg3_in, seg2_in, seg1_in} = p1;
        blank_mask = bk1;
        blink_mask = bl1;
        load       = 1'b1;
      end else if (j == ld2) begin
        {seg4_in, seg3_in, seg2_in, seg1_in} = p2;
        load       = 1'b1;
      end else begin
        load       = 1'b0;
      end
    end
    load = 1'b0;
    fno++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset an_n", 32'(an_n), 32'h0F);
    check("reset seg_n", 32'(seg_n), 32'h7F);
    check("reset frame_tick", 32'(frame_tick), 32'h0);
    check("reset load_ack", 32'(load_ack), 32'h0);
    rst = 1'b0;

    check_frame(P,    4'b0000, 7, 1'b0, -1, P, 4'b0000, 4'b0000, -1, P);
    check_frame(P,    4'b0000, 7, 1'b1,  3, P, 4'b0000, 4'b0000, -1, P);
    check_frame(P,    4'b1111, 7, 1'b0, -1, P, 4'b0000, 4'b0000, -1, P);
    check_frame(P,    4'b1111, 0, 1'b0, -1, P, 4'b0000, 4'b0000, -1, P);
    check_frame(P,    4'b1111, 3, 1'b1, 10, P, 4'b0000, 4'b1000, -1, P);
    check_frame(P,    4'b1111, 3, 1'b0, -1, P, 4'b0000, 4'b0000, -1, P);
    check_frame(P,    4'b0111, 3, 1'b0, -1, P, 4'b0000, 4'b0000, -1, P);
    check_frame(P,    4'b0111, 3, 1'b1,  2, P, 4'b0001, 4'b1000, -1, P);
    check_frame(P,    4'b1110, 3, 1'b0, -1, P, 4'b0000, 4'b0000, -1, P);
    check_frame(P,    4'b1110, 3, 1'b1,  5, ALL0, 4'b0000, 4'b0000, 20, ALL1);
    check_frame(ALL1, 4'b1111, 7, 1'b0, 34, P, 4'b0000, 4'b0000, -1, P);
    check_frame(ALL1, 4'b1111, 7, 1'b1, -1, P, 4'b0000, 4'b0000, -1, P);
    check_frame(P,    4'b1111, 7, 1'b0, -1, P, 4'b0000, 4'b0000, -1, P);

    // Asynchronous reset while digit4 is lit.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre-reset an_n", 32'(an_n), 32'h07);
    #2 rst = 1'b1;
    #1;
    check("async rst an_n", 32'(an_n), 32'h0F);
    check("async rst seg_n", 32'(seg_n), 32'h7F);
    check("async rst frame_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    check_frame(P, 4'b0000, 7, 1'b0, -1, P, 4'b0000, 4'b0000, -1, P);
    check_frame(P, 4'b0000, 7, 1'b1,  0, ALL0, 4'b0000, 4'b0000, -1, P);
    check_frame(ALL0, 4'b1111, 7, 1'b0, -1, P, 4'b0000, 4'b0000, -1, P);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
